// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every signal of the shared memory port arbiter except clk/rst:
//   the fetch requester, the MEM requester, the flush input, the
//   Wishbone-style bus, and the stall/timeout outputs.
//   Signal names keep their _i/_o suffixes as seen from the arbiter.
// Modports:
//   master - the arbiter itself (it masters the shared bus)
//   slave  - the environment: pipeline requesters, stall controller, bus slave
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // fetch requester
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;

  // MEM requester
  logic              mem_req_i;
  logic              mem_we_i;
  logic [SEL_W-1:0]  mem_sel_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ack_o;

  logic              flush_i;

  // shared bus
  logic              bus_cyc_o;
  logic              bus_stb_o;
  logic              bus_we_o;
  logic [SEL_W-1:0]  bus_sel_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;

  // pipeline control
  logic              stallreq_if_o;
  logic              stallreq_mem_o;
  logic              timeout_o;

  modport master (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_ack_o,
    input  flush_i,
    output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i,
    output stallreq_if_o, stallreq_mem_o, timeout_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_ack_o,
    output flush_i,
    input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i,
    input  stallreq_if_o, stallreq_mem_o, timeout_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences one shared Wishbone-style memory port between instruction fetch
//   and the MEM stage. One transaction at a time, MEM has fixed priority.
//   Each transaction ends with a one-cycle ack (RESP state) carrying the read
//   data (0 for stores and timeouts). A wait-state counter releases the bus
//   after WAIT_MAX cycles without bus ack; a flush during a fetch lets the bus
//   cycle finish but suppresses its if_ack_o.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous, active-low reset
//   port - mem_port_arbiter_if.master (requesters, flush, bus, stall/timeout)
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_port_arbiter_if.master     port
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              discard_reg, discard_next;   // current fetch was flushed
  logic              resp_if_reg, resp_if_next;   // RESP belongs to the fetch side
  logic              timeout_reg, timeout_next;   // RESP was reached by timeout
  logic              we_reg, we_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] mem_rdata_reg, mem_rdata_next;
  logic [DATA_W-1:0] done_data;
  logic              busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      discard_reg   <= 1'b0;
      resp_if_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      discard_reg   <= discard_next;
      resp_if_reg   <= resp_if_next;
      timeout_reg   <= timeout_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    discard_next   = discard_reg;
    resp_if_next   = resp_if_reg;
    timeout_next   = timeout_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;
    done_data      = '0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (port.mem_req_i) begin
          state_next = BUSY_MEM;
          we_next    = port.mem_we_i;
          sel_next   = port.mem_sel_i;
          addr_next  = port.mem_addr_i;
          wdata_next = port.mem_wdata_i;
        end else if (port.if_req_i && !port.flush_i) begin
          state_next = BUSY_IF;
          we_next    = 1'b0;
          sel_next   = '1;
          addr_next  = port.if_addr_i;
          wdata_next = '0;
        end
      end

      BUSY_IF, BUSY_MEM: begin
        if (state_reg == BUSY_IF && port.flush_i) begin
          discard_next = 1'b1;
        end
        // An ack on the last allowed wait cycle still counts as a normal completion.
        if (port.bus_ack_i || cnt_reg == CNT_LAST) begin
          state_next   = RESP;
          resp_if_next = (state_reg == BUSY_IF);
          timeout_next = !port.bus_ack_i;
          done_data    = (port.bus_ack_i && !we_reg) ? port.bus_rdata_i : '0;
          if (state_reg == BUSY_IF) begin
            if_rdata_next = done_data;
          end else begin
            mem_rdata_next = done_data;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RESP: begin
        // No grant here: a requester still holding its request is only seen again in IDLE.
        state_next   = IDLE;
        discard_next = 1'b0;
        timeout_next = 1'b0;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == BUSY_IF) || (state_reg == BUSY_MEM);

  assign port.bus_cyc_o   = busy;
  assign port.bus_stb_o   = busy;
  assign port.bus_we_o    = we_reg;
  assign port.bus_sel_o   = sel_reg;
  assign port.bus_addr_o  = addr_reg;
  assign port.bus_wdata_o = wdata_reg;

  assign port.if_rdata_o  = if_rdata_reg;
  assign port.mem_rdata_o = mem_rdata_reg;
  assign port.if_ack_o    = (state_reg == RESP) && resp_if_reg && !discard_reg;
  assign port.mem_ack_o   = (state_reg == RESP) && !resp_if_reg;
  assign port.timeout_o   = (state_reg == RESP) && timeout_reg;

  assign port.stallreq_mem_o = port.mem_req_i & ~port.mem_ack_o;
  assign port.stallreq_if_o  = port.if_req_i  & ~port.if_ack_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (WAIT_MAX = 4). Stimulus pushes the
//   expected acknowledge (side, data, timeout) into a scoreboard queue; a
//   monitor pops and compares whenever if_ack_o or mem_ack_o is seen.
//   A small bus-slave process acks after a programmable number of bus cycles.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int WAIT_MAX = 4;
  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bif)
  );

  typedef struct {
    bit          is_if;
    logic [31:0] data;
    bit          tout;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] slave_q[$];
  int          slave_wait = -1;   // bus cycle index that gets the ack, -1 = never
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic exp_t mk(input bit is_if, input logic [31:0] data, input bit tout);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    e.tout  = tout;
    return e;
  endfunction

  // bus slave
  initial begin
    int bus_cnt;
    bus_cnt         = 0;
    bif.bus_ack_i   = 1'b0;
    bif.bus_rdata_i = JUNK;
    forever begin
      @(negedge clk);
      if (bif.bus_cyc_o) begin
        if (slave_wait >= 0 && bus_cnt == slave_wait) begin
          bif.bus_ack_i   = 1'b1;
          bif.bus_rdata_i = (slave_q.size() > 0) ? slave_q.pop_front() : JUNK;
        end else begin
          bif.bus_ack_i   = 1'b0;
          bif.bus_rdata_i = JUNK;
        end
        bus_cnt++;
      end else begin
        bif.bus_ack_i   = 1'b0;
        bif.bus_rdata_i = JUNK;
        bus_cnt         = 0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (bif.if_ack_o || bif.mem_ack_o) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_ack: got if_ack=%0b mem_ack=%0b required none",
                   bif.if_ack_o, bif.mem_ack_o);
        end else begin
          e   = exp_q.pop_front();
          got = e.is_if ? bif.if_rdata_o : bif.mem_rdata_o;
          tests++;
          if (bif.if_ack_o !== e.is_if || bif.mem_ack_o !== !e.is_if ||
              got !== e.data || bif.timeout_o !== e.tout) begin
            fails++;
            $display("[TB] FAIL sb_ack: got if_ack=%0b mem_ack=%0b data=%0h timeout=%0b required if=%0b data=%0h timeout=%0b",
                     bif.if_ack_o, bif.mem_ack_o, got, bif.timeout_o, e.is_if, e.data, e.tout);
          end else begin
            $display("[TB] ack %s data=%0h timeout=%0b", e.is_if ? "if" : "mem", got, bif.timeout_o);
          end
        end
      end
    end
  end

  initial begin
    bif.if_req_i    = 1'b0;
    bif.if_addr_i   = '0;
    bif.mem_req_i   = 1'b0;
    bif.mem_we_i    = 1'b0;
    bif.mem_sel_i   = '0;
    bif.mem_addr_i  = '0;
    bif.mem_wdata_i = '0;
    bif.flush_i     = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_cyc",       32'(bif.bus_cyc_o), 0);
    chk("rst_stb",       32'(bif.bus_stb_o), 0);
    chk("rst_we_sel",    32'({bif.bus_we_o, bif.bus_sel_o}), 0);
    chk("rst_addr",      bif.bus_addr_o, 0);
    chk("rst_wdata",     bif.bus_wdata_o, 0);
    chk("rst_acks",      32'({bif.if_ack_o, bif.mem_ack_o, bif.timeout_o}), 0);
    chk("rst_rdata",     bif.if_rdata_o | bif.mem_rdata_o, 0);
    chk("rst_stallreq",  32'({bif.stallreq_if_o, bif.stallreq_mem_o}), 0);
    rst = 1'b1;
    step();

    // single load, ack in 2nd bus cycle
    slave_wait = 1;
    slave_q.push_back(32'hDEADBEEF);
    exp_q.push_back(mk(1'b0, 32'hDEADBEEF, 1'b0));
    bif.mem_req_i = 1'b1; bif.mem_addr_i = 32'h100; bif.mem_we_i = 1'b0; bif.mem_sel_i = 4'hF;
    #1 chk("ld_stall_c0", 32'(bif.stallreq_mem_o), 1);
    step();
    chk("ld_cyc_c1",   32'({bif.bus_cyc_o, bif.bus_stb_o}), 32'h3);
    chk("ld_addr_c1",  bif.bus_addr_o, 32'h100);
    chk("ld_we_c1",    32'(bif.bus_we_o), 0);
    chk("ld_stall_c1", 32'(bif.stallreq_mem_o), 1);
    step();
    chk("ld_cyc_c2",   32'({bif.bus_cyc_o, bif.bus_stb_o}), 32'h3);
    chk("ld_ack_c2",   32'(bif.mem_ack_o), 0);
    chk("ld_stall_c2", 32'(bif.stallreq_mem_o), 1);
    step();
    chk("ld_cyc_c3",   32'(bif.bus_cyc_o), 0);
    chk("ld_ack_c3",   32'(bif.mem_ack_o), 1);
    chk("ld_stall_c3", 32'(bif.stallreq_mem_o), 0);
    bif.mem_req_i = 1'b0;
    step();
    chk("ld_idle_c4",  32'({bif.bus_cyc_o, bif.mem_ack_o}), 0);

    // contention, zero-wait slave: MEM first, fetch second
    slave_wait = 0;
    slave_q.push_back(32'h11110000);
    slave_q.push_back(32'h22220000);
    exp_q.push_back(mk(1'b0, 32'h11110000, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h22220000, 1'b0));
    bif.if_req_i = 1'b1; bif.if_addr_i = 32'h200;
    bif.mem_req_i = 1'b1; bif.mem_addr_i = 32'h104; bif.mem_sel_i = 4'b0101; bif.mem_we_i = 1'b0;
    step();
    chk("ct_addr_c1",  bif.bus_addr_o, 32'h104);
    chk("ct_sel_c1",   32'(bif.bus_sel_o), 32'h5);
    step();
    chk("ct_acks_c2",  32'({bif.mem_ack_o, bif.if_ack_o}), 32'h2);
    chk("ct_stif_c2",  32'(bif.stallreq_if_o), 1);
    bif.mem_req_i = 1'b0;
    step();
    chk("ct_cyc_c3",   32'(bif.bus_cyc_o), 0);
    step();
    chk("ct_cyc_c4",   32'(bif.bus_cyc_o), 1);
    chk("ct_addr_c4",  bif.bus_addr_o, 32'h200);
    chk("ct_wesel_c4", 32'({bif.bus_we_o, bif.bus_sel_o}), 32'hF);
    step();
    chk("ct_ifack_c5", 32'(bif.if_ack_o), 1);
    bif.if_req_i = 1'b0;
    step();

    // store
    slave_wait = 0;
    slave_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(mk(1'b0, 32'h0, 1'b0));
    bif.mem_req_i = 1'b1; bif.mem_we_i = 1'b1; bif.mem_sel_i = 4'b0011;
    bif.mem_wdata_i = 32'h1234ABCD; bif.mem_addr_i = 32'h300;
    step();
    chk("st_we_c1",    32'(bif.bus_we_o), 1);
    chk("st_sel_c1",   32'(bif.bus_sel_o), 32'h3);
    chk("st_wdata_c1", bif.bus_wdata_o, 32'h1234ABCD);
    chk("st_addr_c1",  bif.bus_addr_o, 32'h300);
    step();
    chk("st_ack_c2",   32'(bif.mem_ack_o), 1);
    bif.mem_req_i = 1'b0; bif.mem_we_i = 1'b0;
    step();

    // timeout: slave never acks
    slave_wait = -1;
    exp_q.push_back(mk(1'b1, 32'h0, 1'b1));
    bif.if_req_i = 1'b1; bif.if_addr_i = 32'h400;
    for (int i = 1; i <= WAIT_MAX; i++) begin
      step();
      chk("to_cyc_busy", 32'({bif.bus_cyc_o, bif.bus_stb_o}), 32'h3);
      chk("to_tout_busy", 32'(bif.timeout_o), 0);
    end
    step();
    chk("to_cyc_resp",  32'(bif.bus_cyc_o), 0);
    chk("to_tout_resp", 32'(bif.timeout_o), 1);
    chk("to_ifack",     32'(bif.if_ack_o), 1);
    bif.if_req_i = 1'b0;
    step();
    chk("to_tout_idle", 32'({bif.timeout_o, bif.bus_cyc_o}), 0);

    // flush during fetch, then a fresh fetch from the following IDLE
    slave_wait = 2;
    slave_q.push_back(32'h55550000);
    slave_q.push_back(32'h66660000);
    exp_q.push_back(mk(1'b1, 32'h66660000, 1'b0));
    bif.if_req_i = 1'b1; bif.if_addr_i = 32'h500;
    step();
    chk("fl_cyc_c1", 32'(bif.bus_cyc_o), 1);
    step();
    bif.flush_i = 1'b1;
    step();
    bif.flush_i = 1'b0;
    chk("fl_cyc_c3", 32'(bif.bus_cyc_o), 1);
    step();
    chk("fl_cyc_c4",   32'(bif.bus_cyc_o), 0);
    chk("fl_noack_c4", 32'(bif.if_ack_o), 0);
    chk("fl_stall_c4", 32'(bif.stallreq_if_o), 1);
    slave_wait = 0;
    bif.if_addr_i = 32'h504;
    step();
    chk("fl_idle_c5", 32'({bif.bus_cyc_o, bif.if_ack_o}), 0);
    step();
    chk("fl_cyc_c6",  32'(bif.bus_cyc_o), 1);
    chk("fl_addr_c6", bif.bus_addr_o, 32'h504);
    step();
    chk("fl_ack_c7",  32'(bif.if_ack_o), 1);
    bif.if_req_i = 1'b0;
    step();

    // reset in the middle of a MEM transaction
    slave_wait = -1;
    slave_q.push_back(32'h77770000);
    exp_q.push_back(mk(1'b0, 32'h77770000, 1'b0));
    bif.mem_req_i = 1'b1; bif.mem_addr_i = 32'h600; bif.mem_sel_i = 4'hF; bif.mem_we_i = 1'b0;
    step();
    chk("rm_cyc_c1", 32'(bif.bus_cyc_o), 1);
    step();
    rst = 1'b0;
    step();
    chk("rm_cyc_c3",  32'({bif.bus_cyc_o, bif.bus_stb_o, bif.mem_ack_o}), 0);
    chk("rm_addr_c3", bif.bus_addr_o, 0);
    chk("rm_sel_c3",  32'(bif.bus_sel_o), 0);
    rst = 1'b1;
    slave_wait = 0;
    step();
    chk("rm_cyc_c4",  32'(bif.bus_cyc_o), 1);
    chk("rm_addr_c4", bif.bus_addr_o, 32'h600);
    step();
    chk("rm_ack_c5",  32'(bif.mem_ack_o), 1);
    bif.mem_req_i = 1'b0;
    step();
    step();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
